// File: rtl/board_mem_arbiter.sv
// Single-port board RAM arbiter: clear sequencer, then FSM, then display,
// with a starvation guard that lifts the display above the FSM after a run of denials.
//
// state | meaning
// CLEAR | writing CLEAR_VAL to every cell, addresses ascending, no grants
// IDLE  | arbitrating FSM and display accesses
module board_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 2,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0,
  parameter int DISP_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_req,
  output logic              clear_busy,
  input  logic              fsm_req,
  input  logic              fsm_we,
  input  logic [ADDR_W-1:0] fsm_addr,
  input  logic [DATA_W-1:0] fsm_wdata,
  output logic              fsm_gnt,
  output logic              fsm_rvalid,
  output logic [DATA_W-1:0] fsm_rdata,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int WAIT_W = $clog2(DISP_MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(DISP_MAX_WAIT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              fsm_rd_q;
  logic              disp_rd_q;
  logic              grant_ok;
  logic              disp_prio;

  assign clear_busy = (state == CLEAR);
  assign grant_ok   = (state == IDLE) && !clear_req;
  assign disp_prio  = disp_req && (wait_cnt == WAIT_MAX);
  assign disp_gnt   = grant_ok && disp_req && (disp_prio || !fsm_req);
  assign fsm_gnt    = grant_ok && fsm_req && !disp_prio;

  // Read data is only qualified by rvalid, so both ports see the RAM directly.
  assign fsm_rdata  = mem_rdata;
  assign disp_rdata = mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CLEAR;
      clr_cnt     <= '0;
      wait_cnt    <= '0;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_wdata   <= '0;
      fsm_rd_q    <= 1'b0;
      disp_rd_q   <= 1'b0;
      fsm_rvalid  <= 1'b0;
      disp_rvalid <= 1'b0;
    end else begin
      // Tag pipeline runs regardless of state so in-flight reads survive a clear.
      fsm_rd_q    <= fsm_gnt && !fsm_we;
      disp_rd_q   <= disp_gnt;
      fsm_rvalid  <= fsm_rd_q;
      disp_rvalid <= disp_rd_q;
      mem_we      <= 1'b0;
      case (state)
        CLEAR: begin
          if (clear_req) begin
            clr_cnt <= '0;
          end else begin
            mem_we    <= 1'b1;
            mem_addr  <= clr_cnt;
            mem_wdata <= CLEAR_VAL;
            clr_cnt   <= clr_cnt + 1'b1;
            if (clr_cnt == LAST_ADDR) state <= IDLE;
          end
        end
        IDLE: begin
          if (clear_req) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end else if (fsm_gnt) begin
            mem_we    <= fsm_we;
            mem_addr  <= fsm_addr;
            mem_wdata <= fsm_wdata;
          end else if (disp_gnt) begin
            mem_addr  <= disp_addr;
            mem_wdata <= '0;
          end
          if (!disp_req || disp_gnt) begin
            wait_cnt <= '0;
          end else if (!clear_req && wait_cnt != WAIT_MAX) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule
